// File: rtl/uart_tx_frame_fsm_pkg.sv
// Shared definitions for the UART transmit frame FSM: state encoding and line-level constants.
package uart_tx_frame_fsm_pkg;

   // Gray-adjacent order along the normal frame path
   typedef enum logic [2:0] {
      StIdle   = 3'b000,
      StStart  = 3'b001,
      StData   = 3'b011,
      StParity = 3'b010,
      StStop   = 3'b110
   } tx_state_e;

   localparam logic ParEven  = 1'b0;
   localparam logic ParOdd   = 1'b1;
   localparam logic StartBit = 1'b0;
   localparam logic StopBit  = 1'b1;
   localparam logic IdleLine = 1'b1;

endpackage

// File: rtl/uart_tx_frame_fsm_serializer.sv
// Loadable LSB-first shift register with data-bit counter; also captures the parity of the loaded word.
module uart_tx_frame_fsm_serializer #(
   parameter int unsigned DataWidth = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_load,
   input  logic                 i_shift,
   input  logic [DataWidth-1:0] i_data,
   output logic                 o_ser_bit,
   output logic                 o_ser_done,
   output logic                 o_parity
);

   localparam int unsigned CntW = (DataWidth > 1) ? $clog2(DataWidth) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(DataWidth - 1);
   localparam logic [CntW-1:0] OneCnt  = CntW'(1);

   logic [DataWidth-1:0] r_shift;
   logic [CntW-1:0]      r_cnt;
   logic                 r_parity;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_shift  <= '0;
         r_cnt    <= '0;
         r_parity <= 1'b0;
      end else if (i_load) begin
         r_shift  <= i_data;
         r_cnt    <= '0;
         r_parity <= ^i_data;
      end else if (i_shift) begin
         r_shift  <= {1'b0, r_shift[DataWidth-1:1]};
         r_cnt    <= (r_cnt == LastCnt) ? '0 : r_cnt + OneCnt;
      end
   end

   // Bit that will be on the line after the coming edge: peek one ahead while shifting
   assign o_ser_bit  = i_shift ? r_shift[1] : r_shift[0];
   assign o_ser_done = (r_cnt == LastCnt);
   assign o_parity   = r_parity;

endmodule

// File: rtl/uart_tx_frame_fsm.sv
// UART transmit frame FSM: start bit, LSB-first data, optional parity, stop bit; registered outputs.
module uart_tx_frame_fsm
   import uart_tx_frame_fsm_pkg::*;
#(
   parameter int unsigned DataWidth = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [DataWidth-1:0] i_tx_p_data,
   input  logic                 i_tx_d_vld,
   input  logic                 i_par_en,
   input  logic                 i_par_typ,
   output logic                 o_tx_out,
   output logic                 o_busy
);

   tx_state_e r_state;
   tx_state_e w_state_d;
   logic      r_tx_out;
   logic      r_busy;
   logic      r_par_en;
   logic      r_par_typ;
   logic      w_tx_d;
   logic      w_busy_d;
   logic      w_load;
   logic      w_shift;
   logic      w_ser_bit;
   logic      w_ser_done;
   logic      w_parity;
   logic      w_par_bit;

   uart_tx_frame_fsm_serializer #(
      .DataWidth (DataWidth)
   ) u_serializer (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_load     (w_load),
      .i_shift    (w_shift),
      .i_data     (i_tx_p_data),
      .o_ser_bit  (w_ser_bit),
      .o_ser_done (w_ser_done),
      .o_parity   (w_parity)
   );

   assign w_par_bit = (r_par_typ == ParOdd) ? ~w_parity : w_parity;

   // Outputs are registered from the next-state decision, so each state's bit appears with it
   always_comb begin
      w_state_d = StIdle;
      w_tx_d    = IdleLine;
      w_busy_d  = 1'b0;
      w_load    = 1'b0;
      w_shift   = 1'b0;
      case (r_state)
         StIdle: begin
            if (i_tx_d_vld) begin
               w_load    = 1'b1;
               w_state_d = StStart;
               w_tx_d    = StartBit;
               w_busy_d  = 1'b1;
            end
         end
         StStart: begin
            w_state_d = StData;
            w_tx_d    = w_ser_bit;
            w_busy_d  = 1'b1;
         end
         StData: begin
            w_shift  = 1'b1;
            w_busy_d = 1'b1;
            if (w_ser_done) begin
               w_state_d = r_par_en ? StParity : StStop;
               w_tx_d    = r_par_en ? w_par_bit : StopBit;
            end else begin
               w_state_d = StData;
               w_tx_d    = w_ser_bit;
            end
         end
         StParity: begin
            w_state_d = StStop;
            w_tx_d    = StopBit;
            w_busy_d  = 1'b1;
         end
         StStop: begin
            w_state_d = StIdle;
         end
         default: begin
            w_state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= StIdle;
         r_tx_out  <= IdleLine;
         r_busy    <= 1'b0;
         r_par_en  <= 1'b0;
         r_par_typ <= ParEven;
      end else begin
         r_state  <= w_state_d;
         r_tx_out <= w_tx_d;
         r_busy   <= w_busy_d;
         if (w_load) begin
            r_par_en  <= i_par_en;
            r_par_typ <= i_par_typ;
         end
      end
   end

   assign o_tx_out = r_tx_out;
   assign o_busy   = r_busy;

endmodule

// File: tb/tb_uart_tx_frame_fsm.sv
// Self-checking bench for uart_tx_frame_fsm against a frame-level reference model.
module tb_uart_tx_frame_fsm;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] tx_p_data = 8'h00;
   logic       tx_d_vld = 1'b0;
   logic       par_en = 1'b0;
   logic       par_typ = 1'b0;
   logic       tx_out;
   logic       busy;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   uart_tx_frame_fsm #(
      .DataWidth (8)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_tx_p_data (tx_p_data),
      .i_tx_d_vld  (tx_d_vld),
      .i_par_en    (par_en),
      .i_par_typ   (par_typ),
      .o_tx_out    (tx_out),
      .o_busy      (busy)
   );

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference frame: start, data LSB first, optional parity, stop
   function automatic void build_frame(input logic [7:0] data, input logic pen, input logic ptyp,
                                       output logic bits[$]);
      bits = {};
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(data[i]);
      if (pen) bits.push_back(logic'(($countones(data) % 2 == 1) ^ ptyp));
      bits.push_back(1'b1);
   endfunction

   // Entered #1 after the accepting edge; leaves #1 after the edge that ends STOP
   task automatic check_frame(input logic [7:0] data, input logic pen, input logic ptyp,
                              input bit scramble);
      logic bits[$];
      build_frame(data, pen, ptyp, bits);
      for (int i = 0; i < bits.size(); i++) begin
         check_bit($sformatf("frame %h bit%0d tx", data, i), tx_out, bits[i]);
         check_bit($sformatf("frame %h bit%0d busy", data, i), busy, 1'b1);
         if (scramble) begin
            tx_p_data = 8'($urandom);
            par_en    = 1'($urandom);
            par_typ   = 1'($urandom);
         end
         @(posedge clk); #1;
      end
      check_bit($sformatf("frame %h gap busy", data), busy, 1'b0);
      check_bit($sformatf("frame %h gap tx", data), tx_out, 1'b1);
   endtask

   task automatic send(input logic [7:0] data, input logic pen, input logic ptyp,
                       input bit scramble);
      @(negedge clk);
      tx_p_data = data;
      par_en    = pen;
      par_typ   = ptyp;
      tx_d_vld  = 1'b1;
      @(posedge clk); #1;
      tx_d_vld = 1'b0;
      check_frame(data, pen, ptyp, scramble);
   endtask

   initial begin
      logic [7:0] d;
      logic       pe;
      logic       pt;

      // Reset and idle line
      repeat (2) @(posedge clk);
      #1;
      check_bit("reset tx", tx_out, 1'b1);
      check_bit("reset busy", busy, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         check_bit($sformatf("idle%0d tx", i), tx_out, 1'b1);
      end

      // Directed frames
      send(8'hA5, 1'b0, 1'b0, 1'b0);
      send(8'h07, 1'b1, 1'b0, 1'b0);
      send(8'h07, 1'b1, 1'b1, 1'b0);

      // Held valid: second byte taken after exactly one idle cycle
      @(negedge clk);
      tx_p_data = 8'h34;
      par_en    = 1'b0;
      par_typ   = 1'b0;
      tx_d_vld  = 1'b1;
      @(posedge clk); #1;
      tx_p_data = 8'h12;
      check_frame(8'h34, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      tx_d_vld = 1'b0;
      check_frame(8'h12, 1'b0, 1'b0, 1'b0);

      // Reset during data bit 3
      @(negedge clk);
      tx_p_data = 8'hFF;
      par_en    = 1'b1;
      tx_d_vld  = 1'b1;
      @(posedge clk); #1;
      tx_d_vld = 1'b0;
      check_bit("abort start tx", tx_out, 1'b0);
      repeat (4) begin
         @(posedge clk); #1;
      end
      check_bit("abort bit3 tx", tx_out, 1'b1);
      check_bit("abort bit3 busy", busy, 1'b1);
      rst = 1'b1;
      @(posedge clk); #1;
      check_bit("abort tx", tx_out, 1'b1);
      check_bit("abort busy", busy, 1'b0);

      // Reset wins over valid, then the held valid starts a clean frame
      tx_p_data = 8'hC3;
      par_en    = 1'b1;
      par_typ   = 1'b1;
      tx_d_vld  = 1'b1;
      @(posedge clk); #1;
      check_bit("rst+vld busy", busy, 1'b0);
      check_bit("rst+vld tx", tx_out, 1'b1);
      rst = 1'b0;
      @(posedge clk); #1;
      tx_d_vld = 1'b0;
      check_frame(8'hC3, 1'b1, 1'b1, 1'b0);

      // Inputs churning mid-frame
      send(8'h3C, 1'b1, 1'b0, 1'b1);

      // Randomized frames with random idle spacing
      for (int n = 0; n < 40; n++) begin
         d  = 8'($urandom);
         pe = 1'($urandom);
         pt = 1'($urandom);
         repeat ($urandom_range(0, 3)) @(posedge clk);
         send(d, pe, pt, 1'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
